// File: rtl/imem_dmem_arbiter_if.sv
// Bundles the fetch, data-stage and memory-macro signals of the imem/dmem arbiter.
// Latency: none. This is wiring only.
// Backpressure: req/gnt per requester. The macro port has no backpressure.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Instruction fetch port: read-only.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Data stage port: read/write.
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    // 1R1W memory macro: one write port and one registered read port.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr_w;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_we, mem_addr_w, mem_wdata, mem_addr_r,
        input  mem_rdata
    );

    // Requester and macro side.
    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_we, mem_addr_w, mem_wdata, mem_addr_r,
        output mem_rdata
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one 1R1W word memory between instruction fetch (read) and the data stage (read/write).
// Latency: grants are combinational. Read data returns one cycle after the grant, steered by a registered owner flag.
// Backpressure: a denied requester holds its request. Data reads win unless fetch has been starved STARVE_LIMIT times.
module imem_dmem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_dmem_arbiter_if.slave  bus
);

    typedef enum logic {
        PRIO_DM = 1'b0,
        PRIO_IF = 1'b1
    } state_e;

    // The limit ranges from 1 to 15, so 4 bits hold every count value.
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       if_own_q, if_own_d;
    logic       dm_own_q, dm_own_d;

    logic rd_if;     // fetch wants the read port (a flush cancels it)
    logic rd_dm;     // data stage wants the read port
    logic wr_dm;     // data stage wants the write port
    logic conflict;  // both readers want the single read port
    logic if_gnt_c;
    logic dm_gnt_c;
    logic dm_rd_gnt;

    // Decode requests. A flush removes fetch from contention but leaves the data stage alone.
    always_comb begin
        rd_if    = bus.if_req & ~bus.if_flush;
        rd_dm    = bus.dm_req & ~bus.dm_we;
        wr_dm    = bus.dm_req & bus.dm_we;
        conflict = rd_if & rd_dm;
    end

    // Grant decision and priority/starvation next state. Everything is held quiet while in reset.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if_gnt_c = 1'b0;
        dm_gnt_c = 1'b0;
        if (rst_n) begin
            // Writes use their own port, so they never compete with a read.
            dm_gnt_c = wr_dm | (rd_dm & ~(conflict & (state_q == PRIO_IF)));
            if_gnt_c = rd_if & ~(conflict & (state_q == PRIO_DM));
            if (conflict) begin
                if (state_q == PRIO_DM) begin
                    // Fetch lost again. After LIMIT losses in a row it wins the next conflict.
                    if (starve_q + 4'd1 == LIMIT) begin
                        state_d  = PRIO_IF;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + 4'd1;
                    end
                end else begin
                    // Fetch has used its single priority turn. Return to data-first.
                    state_d = PRIO_DM;
                end
            end
            // Any progress by fetch ends its starvation streak.
            if (if_gnt_c) begin
                starve_d = '0;
            end
        end
    end

    // Remember which requester owns the read launched this cycle.
    always_comb begin
        dm_rd_gnt = dm_gnt_c & ~bus.dm_we;
        if_own_d  = if_gnt_c;
        dm_own_d  = dm_rd_gnt;
    end

    // State register. Reset drops any read in flight so no stale rvalid appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PRIO_DM;
            starve_q <= '0;
            if_own_q <= 1'b0;
            dm_own_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if_own_q <= if_own_d;
            dm_own_q <= dm_own_d;
        end
    end

    // Drive the macro and the requester ports.
    // With no read granted, the read address defaults to the fetch address. The value is unused.
    always_comb begin
        bus.if_gnt     = if_gnt_c;
        bus.dm_gnt     = dm_gnt_c;
        bus.mem_we     = dm_gnt_c & bus.dm_we;
        bus.mem_addr_w = bus.dm_addr;
        bus.mem_wdata  = bus.dm_wdata;
        bus.mem_addr_r = dm_rd_gnt ? bus.dm_addr : bus.if_addr;
        bus.if_rvalid  = if_own_q;
        bus.dm_rvalid  = dm_own_q;
        bus.if_rdata   = bus.mem_rdata;
        bus.dm_rdata   = bus.mem_rdata;
    end

    // Only one reader can own the read port in any cycle.
    a_one_owner: assert property (@(posedge clk) disable iff (!rst_n)
        !(if_own_q && dm_own_q));

    // The two grants may overlap only when the data-stage grant is for a write.
    a_one_reader: assert property (@(posedge clk) disable iff (!rst_n)
        !(if_gnt_c && dm_rd_gnt));

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios, then randomized requests.
// Latency: expected read responses are queued at grant time and checked one cycle later.
// Backpressure: modelled requesters hold each request until it is granted.
module tb_imem_dmem_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LIM = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    imem_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural 1R1W macro: a registered read that returns the old word on a same-address write.
    logic [DW-1:0] macro_mem [1<<AW];
    logic [DW-1:0] macro_rd_q;
    always @(posedge clk) begin
        if (bus.mem_we) macro_mem[bus.mem_addr_w] <= bus.mem_wdata;
        macro_rd_q <= macro_mem[bus.mem_addr_r];
    end
    assign bus.mem_rdata = macro_rd_q;

    // Reference model: memory contents, fetch priority turn, and the run of fetch denials.
    logic [DW-1:0] ref_mem [1<<AW];
    bit            ref_if_turn;
    int            ref_denied;

    typedef struct {
        bit            is_if;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each rvalid must match the expectation queued for this cycle.
    always @(negedge clk) begin
        if (bus.if_rvalid || bus.dm_rvalid) begin
            if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                check("unexpected_rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("rvalid_if_owner", 32'(bus.if_rvalid), 32'(mon_e.is_if));
                check("rvalid_dm_owner", 32'(bus.dm_rvalid), 32'(!mon_e.is_if));
                check("rdata", mon_e.is_if ? bus.if_rdata : bus.dm_rdata, mon_e.data);
            end
        end else if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
            mon_e = sbq.pop_front();
            check("missing_rvalid", 32'd0, 32'd1);
        end
    end

    // One clock cycle of stimulus. Returns the grants the reference model expects.
    task automatic step(input bit ir, input logic [AW-1:0] ia, input bit fl,
                        input bit dr, input bit dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd, output bit ig, output bit dg);
        bit want_if, want_dm, both;
        @(posedge clk);
        #1;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.if_flush = fl;
        bus.dm_req   = dr;
        bus.dm_we    = dw;
        bus.dm_addr  = da;
        bus.dm_wdata = dd;
        @(negedge clk);
        want_if = ir && !fl;
        want_dm = dr && !dw;
        both    = want_if && want_dm;
        if (both) begin
            ig = ref_if_turn;
            dg = !ref_if_turn;
        end else begin
            ig = want_if;
            dg = dr;
        end
        check("if_gnt", 32'(bus.if_gnt), 32'(ig));
        check("dm_gnt", 32'(bus.dm_gnt), 32'(dg));
        check("mem_we", 32'(bus.mem_we), 32'(dr && dw));
        if (dr && dw) begin
            check("mem_addr_w", 32'(bus.mem_addr_w), 32'(da));
            check("mem_wdata", bus.mem_wdata, dd);
        end
        if (ig) begin
            check("mem_addr_r_if", 32'(bus.mem_addr_r), 32'(ia));
            sbq.push_back('{is_if: 1'b1, data: ref_mem[ia], cyc: cyc + 1});
        end
        if (dg && want_dm) begin
            check("mem_addr_r_dm", 32'(bus.mem_addr_r), 32'(da));
            sbq.push_back('{is_if: 1'b0, data: ref_mem[da], cyc: cyc + 1});
        end
        // Reads see the old word. Apply the write only after the read expectations are queued.
        if (dr && dw) ref_mem[da] = dd;
        if (both) begin
            if (ref_if_turn) begin
                ref_if_turn = 1'b0;
            end else begin
                ref_denied++;
                if (ref_denied >= LIM) begin
                    ref_if_turn = 1'b1;
                    ref_denied  = 0;
                end
            end
        end
        if (ig) ref_denied = 0;
    endtask

    task automatic idle(output bit ig, output bit dg);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, ig, dg);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_gnt"},    32'(bus.if_gnt),    32'd0);
        check({tag, "_dm_gnt"},    32'(bus.dm_gnt),    32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
        check({tag, "_dm_rvalid"}, 32'(bus.dm_rvalid), 32'd0);
    endtask

    // Bound the whole run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        bit ig, dg;
        bit p_if, p_dm, p_dw, fl;
        logic [AW-1:0] p_ia, p_da;
        logic [DW-1:0] p_dd;

        for (int i = 0; i < (1 << AW); i++) begin
            macro_mem[i] = 32'h1000_0000 + 32'(i);
            ref_mem[i]   = 32'h1000_0000 + 32'(i);
        end
        macro_mem[5] = 32'hDEAD_BEEF;
        ref_mem[5]   = 32'hDEAD_BEEF;
        macro_mem[9] = 32'h0000_0001;
        ref_mem[9]   = 32'h0000_0001;
        ref_if_turn  = 1'b0;
        ref_denied   = 0;

        // Test 1: reset with both requests asserted.
        bus.if_req = 1'b1; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("t1_rst");
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        rst_n      = 1'b1;
        step(1'b1, 10'd5, 1'b0, 1'b0, 1'b0, '0, '0, ig, dg);
        idle(ig, dg);
        check("t1_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("t1_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);

        // Test 2: continuous read conflict. Fetch wins one cycle in every four.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 10'd20, 1'b0, 1'b1, 1'b0, 10'd30, '0, ig, dg);
            check("t2_if_gnt_pattern", 32'(bus.if_gnt), 32'((i % 4) == 3));
            check("t2_dm_gnt_pattern", 32'(bus.dm_gnt), 32'((i % 4) != 3));
        end

        // Test 3: a data write and a fetch read are granted in the same cycle.
        step(1'b1, 10'd8, 1'b0, 1'b1, 1'b1, 10'd7, 32'h1234_5678, ig, dg);
        check("t3_if_gnt", 32'(bus.if_gnt), 32'd1);
        check("t3_dm_gnt", 32'(bus.dm_gnt), 32'd1);
        check("t3_mem_we", 32'(bus.mem_we), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 10'd7, '0, ig, dg);
        check("t3_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        idle(ig, dg);
        check("t3_dm_rvalid", 32'(bus.dm_rvalid), 32'd1);
        check("t3_dm_rdata", bus.dm_rdata, 32'h1234_5678);

        // Test 4: a same-address read and write return the old word.
        step(1'b1, 10'd9, 1'b0, 1'b1, 1'b1, 10'd9, 32'h2, ig, dg);
        idle(ig, dg);
        check("t4_old_word", bus.if_rdata, 32'h1);
        step(1'b1, 10'd9, 1'b0, 1'b0, 1'b0, '0, '0, ig, dg);
        idle(ig, dg);
        check("t4_new_word", bus.if_rdata, 32'h2);

        // Test 5: a flush leaves the starvation count untouched.
        step(1'b1, 10'd10, 1'b0, 1'b1, 1'b0, 10'd11, '0, ig, dg);
        step(1'b1, 10'd10, 1'b0, 1'b1, 1'b0, 10'd11, '0, ig, dg);
        step(1'b1, 10'd10, 1'b1, 1'b1, 1'b0, 10'd11, '0, ig, dg);
        check("t5_flush_if_gnt", 32'(bus.if_gnt), 32'd0);
        check("t5_flush_dm_gnt", 32'(bus.dm_gnt), 32'd1);
        idle(ig, dg);
        check("t5_no_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        step(1'b1, 10'd10, 1'b0, 1'b1, 1'b0, 10'd11, '0, ig, dg);
        check("t5_third_denial", 32'(bus.if_gnt), 32'd0);
        step(1'b1, 10'd10, 1'b0, 1'b1, 1'b0, 10'd11, '0, ig, dg);
        check("t5_if_turn", 32'(bus.if_gnt), 32'd1);
        idle(ig, dg);

        // Test 6: reset in the cycle after a data read grant.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 10'd12, '0, ig, dg);
        @(posedge clk);
        #1;
        check("t6_rvalid_before_reset", 32'(bus.dm_rvalid), 32'd1);
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_we = 1'b0;
        sbq.delete();
        ref_if_turn = 1'b0;
        ref_denied  = 0;
        #1;
        check("t6_rvalid_dropped", 32'(bus.dm_rvalid), 32'd0);
        repeat (2) @(negedge clk);
        check_reset_outputs("t6_rst");
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        rst_n      = 1'b1;
        idle(ig, dg);
        check("t6_no_rvalid_after", 32'(bus.dm_rvalid), 32'd0);
        idle(ig, dg);

        // Randomized traffic. Requests are held until granted and addresses share a small window.
        p_if = 1'b0; p_dm = 1'b0; p_dw = 1'b0;
        p_ia = '0; p_da = '0; p_dd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!p_if && ($urandom_range(0, 2) != 0)) begin
                p_if = 1'b1;
                p_ia = AW'($urandom_range(0, 15));
            end
            if (!p_dm && ($urandom_range(0, 1) != 0)) begin
                p_dm = 1'b1;
                p_dw = ($urandom_range(0, 2) == 0);
                p_da = AW'($urandom_range(0, 15));
                p_dd = $urandom;
            end
            fl = ($urandom_range(0, 7) == 0);
            step(p_if, p_ia, fl, p_dm, p_dw, p_da, p_dd, ig, dg);
            if (ig) p_if = 1'b0;
            if (dg) p_dm = 1'b0;
            if (fl) p_ia = AW'($urandom_range(0, 15));
        end
        repeat (3) idle(ig, dg);
        check("drain_scoreboard", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
